mem_arbiter: RTL and testbench

Two-client arbiter that shares the single tsim host memory port between two compute engines. Each client issues one request (read or write, 1–256 words). The arbiter grants round-robin and forwards the request to memory. It then routes that transaction's read or write data beats exclusively to the owning client until the last beat completes. It sits between the compute engines and the memory interface in the tsim accelerator top level.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client round-robin arbiter onto the single host memory port
// Grants in IDLE with zero latency, then steers one burst's data beats to the owner only.
module mem_arbiter #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     c0_req_valid,
    output logic                     c0_req_ready,
    input  logic                     c0_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
    input  logic                     c0_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
    output logic                     c0_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
    input  logic                     c0_rd_ready,
    input  logic                     c1_req_valid,
    output logic                     c1_req_ready,
    input  logic                     c1_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
    input  logic                     c1_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
    output logic                     c1_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
    input  logic                     c1_rd_ready,
    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     owner
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    prio_q, prio_d;
    logic [MEM_LEN_BITS-1:0] cnt_q, cnt_d;
    logic [MEM_LEN_BITS-1:0] len_q, len_d;

    logic sel;
    logic req_any;
    logic beat;

    // With no contention the lone requester wins; otherwise prio decides.
    // sel stays 0 with no requests so the memory request fields follow client 0.
    assign sel     = (c0_req_valid && c1_req_valid) ? prio_q : c1_req_valid;
    assign req_any = reset && (c0_req_valid || c1_req_valid);

    assign mem_req_opcode = sel ? c1_req_opcode : c0_req_opcode;
    assign mem_req_len    = sel ? c1_req_len    : c0_req_len;
    assign mem_req_addr   = sel ? c1_req_addr   : c0_req_addr;
    assign mem_wr_bits    = owner_q ? c1_wr_bits : c0_wr_bits;
    assign c0_rd_bits     = mem_rd_bits;
    assign c1_rd_bits     = mem_rd_bits;
    assign busy           = (state_q != IDLE);
    assign owner          = owner_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        prio_d        = prio_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        mem_req_valid = 1'b0;
        c0_req_ready  = 1'b0;
        c1_req_ready  = 1'b0;
        mem_rd_ready  = 1'b0;
        c0_rd_valid   = 1'b0;
        c1_rd_valid   = 1'b0;
        mem_wr_valid  = 1'b0;
        beat          = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    mem_req_valid = 1'b1;
                    c0_req_ready  = !sel;
                    c1_req_ready  = sel;
                    owner_d       = sel;
                    len_d         = mem_req_len;
                    cnt_d         = '0;
                    state_d       = mem_req_opcode ? WRITE : READ;
                end
            end
            READ: begin
                // Ready comes only from the owner so there is no path from mem_rd_valid.
                mem_rd_ready = owner_q ? c1_rd_ready : c0_rd_ready;
                c0_rd_valid  = !owner_q && mem_rd_valid;
                c1_rd_valid  = owner_q && mem_rd_valid;
                beat         = mem_rd_valid && mem_rd_ready;
            end
            WRITE: begin
                mem_wr_valid = owner_q ? c1_wr_valid : c0_wr_valid;
                beat         = mem_wr_valid;
            end
            default: state_d = IDLE;
        endcase
        // Full-width compare: len of all-ones completes on the final beat, never on wrap.
        if (beat) begin
            if (cnt_q == len_q) begin
                state_d = IDLE;
                prio_d  = !owner_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        c0_req_valid = 0, c0_req_opcode = 0, c0_wr_valid = 0, c0_rd_ready = 0;
    logic [7:0]  c0_req_len = 0;
    logic [63:0] c0_req_addr = 0, c0_wr_bits = 0;
    logic        c1_req_valid = 0, c1_req_opcode = 0, c1_wr_valid = 0, c1_rd_ready = 0;
    logic [7:0]  c1_req_len = 0;
    logic [63:0] c1_req_addr = 0, c1_wr_bits = 0;
    logic        mem_rd_valid = 0;
    logic [63:0] mem_rd_bits = 0;
    logic        c0_req_ready, c1_req_ready, c0_rd_valid, c1_rd_valid;
    logic [63:0] c0_rd_bits, c1_rd_bits;
    logic        mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_ready, busy, owner;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr, mem_wr_bits;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_opcode(c0_req_opcode),
        .c0_req_len(c0_req_len), .c0_req_addr(c0_req_addr), .c0_wr_valid(c0_wr_valid),
        .c0_wr_bits(c0_wr_bits), .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits),
        .c0_rd_ready(c0_rd_ready),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_opcode(c1_req_opcode),
        .c1_req_len(c1_req_len), .c1_req_addr(c1_req_addr), .c1_wr_valid(c1_wr_valid),
        .c1_wr_bits(c1_wr_bits), .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits),
        .c1_rd_ready(c1_rd_ready),
        .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
        .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
        .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic        v0, op0;
        logic [7:0]  len0;
        logic [63:0] addr0;
        logic        v1, op1;
        logic [7:0]  len1;
        logic [63:0] addr1;
        logic        e_rdy0, e_rdy1, e_mvalid, e_op;
        logic [7:0]  e_len;
        logic [63:0] e_addr;
        logic        e_busy, e_owner;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        c0_req_valid = 0; c1_req_valid = 0; c0_wr_valid = 0; c1_wr_valid = 0;
        c0_rd_ready = 0; c1_rd_ready = 0; mem_rd_valid = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        clear_inputs();
        reset = 0;
        @(negedge clock);
        reset = 1;
    endtask

    task automatic do_req(input bit who, input logic op, input logic [7:0] len, input logic [63:0] addr);
        @(negedge clock);
        if (who == 0) begin
            c0_req_valid = 1; c0_req_opcode = op; c0_req_len = len; c0_req_addr = addr;
        end else begin
            c1_req_valid = 1; c1_req_opcode = op; c1_req_len = len; c1_req_addr = addr;
        end
        #1;
        check("grant_ready", who ? c1_req_ready : c0_req_ready, 1);
        check("grant_mem_valid", mem_req_valid, 1);
        check("grant_addr", mem_req_addr, addr);
        check("grant_len", mem_req_len, len);
        check("grant_op", mem_req_opcode, op);
        @(posedge clock);
        #1;
        c0_req_valid = 0;
        c1_req_valid = 0;
    endtask

    // Drives memory read beats until n are accepted; returns in the following IDLE cycle.
    task automatic read_beats(input bit who, input int n, input int stall_at);
        int  got = 0;
        int  bad_rdy = 0;
        int  bad_route = 0;
        bit  early = 0;
        bit  stall;
        for (int c = 0; c < 600 && got < n; c++) begin
            @(negedge clock);
            stall        = (c >= stall_at) && (c < stall_at + 3);
            mem_rd_valid = 1;
            mem_rd_bits  = 64'hBEEF_0000_0000_0000 | 64'(c);
            c0_rd_ready  = (who == 0) ? !stall : 1'b1;
            c1_rd_ready  = (who == 1) ? !stall : 1'b1;
            #1;
            if (!busy) early = 1;
            if (mem_rd_ready !== !stall) bad_rdy++;
            if (who == 0 && (c0_rd_valid !== 1 || c1_rd_valid !== 0 || c0_rd_bits !== mem_rd_bits)) bad_route++;
            if (who == 1 && (c1_rd_valid !== 1 || c0_rd_valid !== 0 || c1_rd_bits !== mem_rd_bits)) bad_route++;
            if (mem_rd_valid && mem_rd_ready) got++;
        end
        check("rd_beat_count", 64'(got), 64'(n));
        check("rd_early_idle", 64'(early), 0);
        check("rd_ready_mux", 64'(bad_rdy), 0);
        check("rd_route", 64'(bad_route), 0);
        @(negedge clock);
        #1;
        check("rd_done_busy", busy, 0);
        check("rd_idle_drop", {mem_rd_ready, c0_rd_valid, c1_rd_valid}, 0);
        mem_rd_valid = 0;
        c0_rd_ready  = 0;
        c1_rd_ready  = 0;
    endtask

    initial begin
        int wcount;
        int wbad;

        vecs[0] = '{0, 1, 8'd7, 64'h10,  0, 0, 8'd2, 64'h20,  0, 0, 0, 1, 8'd7, 64'h10,  0, 0};
        vecs[1] = '{1, 0, 8'd3, 64'h100, 0, 1, 8'd9, 64'h999, 1, 0, 1, 0, 8'd3, 64'h100, 1, 0};
        vecs[2] = '{0, 0, 8'd9, 64'h999, 1, 1, 8'd1, 64'h200, 0, 1, 1, 1, 8'd1, 64'h200, 1, 1};
        vecs[3] = '{1, 1, 8'd2, 64'h300, 1, 0, 8'd4, 64'h400, 1, 0, 1, 1, 8'd2, 64'h300, 1, 0};

        // Reset state, with a client request held to show grants are suppressed.
        c0_req_valid = 1;
        #3;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_valids", {mem_req_valid, c0_req_ready, c1_req_ready, mem_wr_valid, mem_rd_ready}, 0);
        c0_req_valid = 0;
        @(negedge clock);
        reset = 1;

        foreach (vecs[i]) begin
            @(negedge clock);
            c0_req_valid = vecs[i].v0; c0_req_opcode = vecs[i].op0;
            c0_req_len = vecs[i].len0; c0_req_addr = vecs[i].addr0;
            c1_req_valid = vecs[i].v1; c1_req_opcode = vecs[i].op1;
            c1_req_len = vecs[i].len1; c1_req_addr = vecs[i].addr1;
            #1;
            check($sformatf("v%0d_rdy0", i), c0_req_ready, vecs[i].e_rdy0);
            check($sformatf("v%0d_rdy1", i), c1_req_ready, vecs[i].e_rdy1);
            check($sformatf("v%0d_mvalid", i), mem_req_valid, vecs[i].e_mvalid);
            check($sformatf("v%0d_op", i), mem_req_opcode, vecs[i].e_op);
            check($sformatf("v%0d_len", i), mem_req_len, vecs[i].e_len);
            check($sformatf("v%0d_addr", i), mem_req_addr, vecs[i].e_addr);
            @(negedge clock);
            #1;
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("v%0d_owner", i), owner, vecs[i].e_owner);
            check($sformatf("v%0d_held_off", i), {mem_req_valid, c0_req_ready, c1_req_ready}, 0);
            pulse_reset();
        end

        // Single read on c0; leaves prio at 1.
        do_req(0, 0, 8'd3, 64'h100);
        read_beats(0, 4, 1000);

        // Contention from reset release.
        @(negedge clock);
        clear_inputs();
        reset = 0;
        c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 8'd1; c0_req_addr = 64'hA00;
        c1_req_valid = 1; c1_req_opcode = 0; c1_req_len = 8'd0; c1_req_addr = 64'hB00;
        @(negedge clock);
        reset = 1;
        #1;
        check("cont_c0_first", {c0_req_ready, c1_req_ready}, 2'b10);
        check("cont_addr0", mem_req_addr, 64'hA00);
        @(posedge clock);
        #1;
        c0_req_valid = 0;
        read_beats(0, 2, 1000);
        check("cont_c1_next", {c0_req_ready, c1_req_ready, mem_req_valid}, 3'b011);
        check("cont_addr1", mem_req_addr, 64'hB00);
        @(posedge clock);
        #1;
        c1_req_valid = 0;
        read_beats(1, 1, 1000);

        // prio is back to 0: pair goes to c0, then after c0 completes the next pair goes to c1.
        @(negedge clock);
        c0_req_valid = 1; c1_req_valid = 1;
        c0_req_len = 8'd0; c1_req_len = 8'd0;
        #1;
        check("pair2_c0", {c0_req_ready, c1_req_ready}, 2'b10);
        @(posedge clock);
        #1;
        c1_req_valid = 0; c0_req_valid = 0;
        read_beats(0, 1, 1000);
        c0_req_valid = 1; c1_req_valid = 1;
        #1;
        check("pair3_c1", {c0_req_ready, c1_req_ready}, 2'b01);
        @(posedge clock);
        #1;
        c0_req_valid = 0; c1_req_valid = 0;
        read_beats(1, 1, 1000);

        // Backpressure mid-burst.
        do_req(0, 0, 8'd5, 64'h600);
        read_beats(0, 6, 2);

        // Maximum length burst.
        do_req(0, 0, 8'd255, 64'h700);
        read_beats(0, 256, 1000);

        // Write isolation: c0 toggles wr_valid while c1 owns a 2-beat write.
        do_req(1, 1, 8'd1, 64'h800);
        wcount = 0;
        wbad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            c0_wr_valid = (i % 2 == 0);
            c0_wr_bits  = 64'hDEAD;
            c1_wr_valid = (i == 1 || i == 3);
            c1_wr_bits  = 64'hC100 + 64'(i);
            #1;
            if (mem_wr_valid !== c1_wr_valid) wbad++;
            if (mem_wr_valid) begin
                wcount++;
                if (mem_wr_bits !== c1_wr_bits) wbad++;
            end
            if (i == 4) check("wr_done_busy", busy, 0);
        end
        check("wr_isolation", 64'(wbad), 0);
        check("wr_count", 64'(wcount), 2);
        c0_wr_valid = 0;
        c1_wr_valid = 0;

        // Asynchronous reset during a c1 write after two beats.
        do_req(1, 1, 8'd5, 64'h900);
        @(negedge clock); c1_wr_valid = 1;
        @(negedge clock); c1_wr_valid = 1;
        @(negedge clock);
        c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 8'd1; c1_req_addr = 64'h500;
        mem_rd_valid = 1;
        #1;
        check("pre_rst_busy", {busy, owner}, 2'b11);
        #1;
        reset = 0;
        #1;
        check("async_busy", busy, 0);
        check("async_owner", owner, 0);
        check("async_valids", {mem_wr_valid, mem_req_valid, c1_req_ready, mem_rd_ready, c1_rd_valid}, 0);
        @(negedge clock);
        reset = 1;
        c1_wr_valid = 0;
        mem_rd_valid = 0;
        #1;
        check("post_rst_grant", {c1_req_ready, mem_req_valid}, 2'b11);
        check("post_rst_addr", mem_req_addr, 64'h500);
        @(posedge clock);
        #1;
        c1_req_valid = 0;
        @(negedge clock); c1_wr_valid = 1; c1_wr_bits = 64'h51;
        #1;
        check("post_rst_beat1", {mem_wr_valid, busy}, 2'b11);
        @(negedge clock); c1_wr_valid = 1; c1_wr_bits = 64'h52;
        #1;
        check("post_rst_beat2", {mem_wr_valid, busy}, 2'b11);
        @(negedge clock); c1_wr_valid = 0;
        #1;
        check("post_rst_done", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
